// File: rtl/burst_accumulator_pkg.sv
// Shared definitions for the burst accumulator: op-code constants and FSM state type.
package burst_accumulator_pkg;

   localparam int unsigned OP_W = 3;

   // Operation selector encodings; every code above OP_XOR is a load.
   localparam logic [OP_W-1:0] OP_ADD = 3'b000;
   localparam logic [OP_W-1:0] OP_SUB = 3'b001;
   localparam logic [OP_W-1:0] OP_AND = 3'b010;
   localparam logic [OP_W-1:0] OP_OR  = 3'b011;
   localparam logic [OP_W-1:0] OP_XOR = 3'b100;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // True for the op codes that can overflow (add and sub).
   function automatic logic is_arith(input logic [OP_W-1:0] op);
      return (op == OP_ADD) || (op == OP_SUB);
   endfunction

endpackage

// File: rtl/acc_alu.sv
// Combinational accumulator datapath: result_c = acc <op> x.
// Optional macro: BURST_ACCUMULATOR_SAT_EN -- when defined, an overflowing
// add/sub clamps to the signed extreme; otherwise it wraps modulo 2^WIDTH.
// Ports:
//   op         operation selector
//   x          operand (two's complement)
//   acc        current accumulator value
//   result_c   next accumulator value
//   overflow_c signed overflow of an add/sub (never set for logic ops/load)
module acc_alu
   import burst_accumulator_pkg::*;
#(
   parameter int unsigned WIDTH = 6
) (
   input  logic [OP_W-1:0]  op,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] acc,
   output logic [WIDTH-1:0] result_c,
   output logic             overflow_c
);

   localparam int unsigned MSB = WIDTH - 1;
   localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] diff;
   logic             add_ovf;
   logic             sub_ovf;

   assign sum  = acc + x;
   assign diff = acc - x;

   // Overflow when the result sign disagrees with what the operand signs imply.
   assign add_ovf = (acc[MSB] == x[MSB]) && (sum[MSB]  != acc[MSB]);
   assign sub_ovf = (acc[MSB] != x[MSB]) && (diff[MSB] != acc[MSB]);

   // Op select; logic ops and load can never overflow.
   always_comb begin
      result_c   = x;
      overflow_c = 1'b0;
      unique case (op)
         OP_ADD: begin
            result_c   = sum;
            overflow_c = add_ovf;
         end
         OP_SUB: begin
            result_c   = diff;
            overflow_c = sub_ovf;
         end
         OP_AND:  result_c = acc & x;
         OP_OR:   result_c = acc | x;
         OP_XOR:  result_c = acc ^ x;
         default: result_c = x;
      endcase
`ifdef BURST_ACCUMULATOR_SAT_EN
      // Overflow direction follows the accumulator sign for both add and sub.
      if (overflow_c && is_arith(op)) begin
         result_c = acc[MSB] ? MIN_NEG : MAX_POS;
      end
`endif
   end

endmodule

// File: rtl/burst_accumulator.sv
// Burst accumulator: accepts a burst of len operands, folds each into an
// accumulator with a per-operand op, then presents the result until consumed.
// Optional macro: BURST_ACCUMULATOR_SAT_EN (saturating add/sub, see acc_alu).
// Ports:
//   clock, reset     clock and synchronous active-high reset
//   start, len       burst request and length (sampled in IDLE)
//   op, x, in_valid  operand stream; in_ready high while in RUN
//   s                accumulator register
//   out_valid        result valid (DONE); out_ready consumes it
//   ovf              sticky signed-overflow flag for the current burst
module burst_accumulator
   import burst_accumulator_pkg::*;
#(
   parameter int unsigned WIDTH = 6,
   parameter int unsigned CNT_W = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [CNT_W-1:0] len,
   input  logic [OP_W-1:0]  op,
   input  logic [WIDTH-1:0] x,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] s,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             ovf
);

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic [WIDTH-1:0] acc_nxt;
   logic             ovf_nxt;
   logic             in_ready_nxt;
   logic             out_valid_nxt;

   logic [WIDTH-1:0] alu_result;
   logic             alu_ovf;

   acc_alu #(
      .WIDTH(WIDTH)
   ) u_alu (
      .op        (op),
      .x         (x),
      .acc       (s),
      .result_c  (alu_result),
      .overflow_c(alu_ovf)
   );

   // State, counter, accumulator and registered handshake outputs.
   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         s         <= '0;
         ovf       <= 1'b0;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         s         <= acc_nxt;
         ovf       <= ovf_nxt;
         in_ready  <= in_ready_nxt;
         out_valid <= out_valid_nxt;
      end
   end

   // Next-state and datapath update; handshakes are decoded from the next state
   // so in_ready/out_valid come straight from flops.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      acc_nxt   = s;
      ovf_nxt   = ovf;

      unique case (state)
         ST_IDLE: begin
            if (start) begin
               acc_nxt   = '0;
               ovf_nxt   = 1'b0;
               cnt_nxt   = len;
               state_nxt = (len != '0) ? ST_RUN : ST_DONE;
            end
         end
         ST_RUN: begin
            if (in_valid) begin
               acc_nxt = alu_result;
               ovf_nxt = ovf | alu_ovf;
               cnt_nxt = cnt - CNT_W'(1);
               // cnt is never 0 in RUN, so 1 marks the final operand.
               if (cnt == CNT_W'(1)) begin
                  state_nxt = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            // start is deliberately not looked at here, even alongside out_ready.
            if (out_ready) begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase

      in_ready_nxt  = (state_nxt == ST_RUN);
      out_valid_nxt = (state_nxt == ST_DONE);
   end

endmodule

// File: tb/tb_burst_accumulator.sv
// Directed bench for burst_accumulator (WIDTH=6, CNT_W=4) with a result
// scoreboard: expected results are queued by the stimulus and popped by a
// monitor whenever out_valid rises.
module tb_burst_accumulator;

   localparam int unsigned WIDTH = 6;
   localparam int unsigned CNT_W = 4;

   localparam logic [2:0] ADD  = 3'b000;
   localparam logic [2:0] SUB  = 3'b001;
   localparam logic [2:0] AND_ = 3'b010;
   localparam logic [2:0] OR_  = 3'b011;
   localparam logic [2:0] XOR_ = 3'b100;
   localparam logic [2:0] LD   = 3'b101;
   localparam logic [2:0] LD7  = 3'b111;

   typedef struct {
      logic [WIDTH-1:0] s;
      logic             ovf;
   } exp_t;

   logic             clock = 1'b0;
   logic             reset = 1'b1;
   logic             start = 1'b0;
   logic [CNT_W-1:0] len = '0;
   logic [2:0]       op = '0;
   logic [WIDTH-1:0] x = '0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] s;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic             ovf;

   int   vectors = 0;
   int   miscompares = 0;
   exp_t exp_q[$];

   burst_accumulator #(
      .WIDTH(WIDTH),
      .CNT_W(CNT_W)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .start    (start),
      .len      (len),
      .op       (op),
      .x        (x),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .s        (s),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .ovf      (ovf)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic push_exp(input logic [WIDTH-1:0] es, input logic eo);
      exp_t e;
      e.s   = es;
      e.ovf = eo;
      exp_q.push_back(e);
   endtask

   // Monitor: one scoreboard pop per result presentation.
   initial begin
      logic ov_prev;
      exp_t e;
      ov_prev = 1'b0;
      forever begin
         @(negedge clock);
         if (out_valid && !ov_prev) begin
            if (exp_q.size() == 0) begin
               check("unexpected_result", 32'(s), 32'hFFFF_FFFF);
            end else begin
               e = exp_q.pop_front();
               check("result_s", 32'(s), 32'(e.s));
               check("result_ovf", 32'(ovf), 32'(e.ovf));
            end
         end
         ov_prev = out_valid;
      end
   end

   task automatic start_burst(input logic [CNT_W-1:0] l);
      @(posedge clock); #1;
      start = 1'b1;
      len   = l;
      @(posedge clock); #1;
      start = 1'b0;
   endtask

   task automatic send(input logic [2:0] o, input logic [WIDTH-1:0] v);
      op       = o;
      x        = v;
      in_valid = 1'b1;
      @(posedge clock); #1;
      in_valid = 1'b0;
   endtask

   task automatic finish_burst();
      int n;
      n = 0;
      while (!out_valid && n < 20) begin
         @(posedge clock); #1;
         n++;
      end
      if (!out_valid) check("done_timeout", 32'(out_valid), 32'd1);
      @(negedge clock);
      out_ready = 1'b1;
      @(posedge clock); #1;
      out_ready = 1'b0;
      check("idle_after_handshake", 32'({out_valid, in_ready}), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
      check("reset_in_ready", 32'(in_ready), 32'd0);
      check("reset_out_valid", 32'(out_valid), 32'd0);
      check("reset_s", 32'(s), 32'd0);
      check("reset_ovf", 32'(ovf), 32'd0);

      // Three adds on consecutive cycles; result valid right after the last accept.
      push_exp(6'd21, 1'b0);
      start_burst(4'd3);
      check("run_in_ready", 32'(in_ready), 32'd1);
      send(ADD, 6'd5);
      check("s_one_cycle_after_accept", 32'(s), 32'd5);
      in_valid = 1'b1;
      send(ADD, 6'd7);
      send(ADD, 6'd9);
      check("done_latency", 32'(out_valid), 32'd1);
      check("done_in_ready", 32'(in_ready), 32'd0);
      finish_burst();

      // 31 + 1 overflows.
`ifdef BURST_ACCUMULATOR_SAT_EN
      push_exp(6'h1F, 1'b1);
`else
      push_exp(6'h20, 1'b1);
`endif
      start_burst(4'd2);
      send(ADD, 6'd31);
      send(ADD, 6'd1);
      finish_burst();

      // 0 - (-32) overflows.
`ifdef BURST_ACCUMULATOR_SAT_EN
      push_exp(6'h1F, 1'b1);
`else
      push_exp(6'h20, 1'b1);
`endif
      start_burst(4'd2);
      send(LD, 6'd0);
      send(SUB, 6'h20);
      finish_burst();

      // Logic ops only; ovf must be cleared by the new start.
      push_exp(6'h03, 1'b0);
      start_burst(4'd4);
      send(LD7, 6'h3C);
      send(AND_, 6'h0F);
      send(OR_, 6'h30);
      send(XOR_, 6'h3F);
      finish_burst();

      // -5 - 10 = -15, then + (-20) = -35 underflows.
`ifdef BURST_ACCUMULATOR_SAT_EN
      push_exp(6'h20, 1'b1);
`else
      push_exp(6'h1D, 1'b1);
`endif
      start_burst(4'd3);
      send(ADD, 6'h3B);
      send(SUB, 6'd10);
      send(ADD, 6'h2C);
      finish_burst();

      // ovf stays set through a later load.
      push_exp(6'd5, 1'b1);
      start_burst(4'd3);
      send(ADD, 6'd31);
      send(ADD, 6'd1);
      send(LD7, 6'd5);
      finish_burst();

      // Zero-length burst: DONE immediately with s=0, then held while stimulus toggles.
      push_exp(6'd0, 1'b0);
      start_burst(4'd0);
      check("len0_done", 32'(out_valid), 32'd1);
      for (int i = 0; i < 5; i++) begin
         start    = i[0];
         in_valid = ~i[0];
         len      = 4'd5;
         op       = ADD;
         x        = 6'd9;
         @(posedge clock); #1;
         check("hold_out_valid", 32'(out_valid), 32'd1);
         check("hold_in_ready", 32'(in_ready), 32'd0);
         check("hold_s", 32'(s), 32'd0);
      end
      in_valid = 1'b0;
      // start together with out_ready: only DONE->IDLE is taken.
      start     = 1'b1;
      out_ready = 1'b1;
      @(posedge clock); #1;
      start     = 1'b0;
      out_ready = 1'b0;
      check("start_ignored_in_done", 32'({out_valid, in_ready}), 32'd0);
      @(posedge clock); #1;
      check("still_idle", 32'({out_valid, in_ready}), 32'd0);

      // Reset after 2 of 4 accepts (with ovf already set).
      start_burst(4'd4);
      send(ADD, 6'd31);
      send(ADD, 6'd1);
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      check("midreset_s", 32'(s), 32'd0);
      check("midreset_ovf", 32'(ovf), 32'd0);
      check("midreset_idle", 32'({out_valid, in_ready}), 32'd0);
      push_exp(6'h2A, 1'b0);
      start_burst(4'd1);
      send(XOR_, 6'h2A);
      finish_burst();

      repeat (3) @(posedge clock);
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
